// File: rtl/mem_pkg.sv
// mem_pkg: byte-enable constants, width codes and responder FSM state shared by the data-memory path
package mem_pkg;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [1:0] W_BYTE  = 2'b01;
  localparam logic [1:0] W_WORD  = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  function automatic logic be_legal(input logic [3:0] be);
    return be == BE_NONE || be == BE_B0 || be == BE_B1 || be == BE_B2 || be == BE_B3 || be == BE_WORD;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32-bit word array with per-byte-lane write enables and an asynchronous read port
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [3:0][7:0] mem [DEPTH];
  // write only the enabled byte lanes; the others keep their contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][i] <= wdata[8*i +: 8];
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data RAM responder with valid/ready handshake and fixed latency; DMEM_BE_CHECK_EN enables byte-enable legality checking
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_wbyte_enable,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = ADDR_W - 2;
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic we_q, we_d, err_q, err_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d, ram_rdata;
  logic in_oor, be_bad, in_err, accept, ram_we, cur_we, cur_err;
  logic [AW-1:0] in_idx, cur_idx;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign in_idx = req_addr[AW+1:2];
  assign in_oor = req_addr[ADDR_W-1:2] >= IW'(DEPTH);
`ifdef DMEM_BE_CHECK_EN
  assign be_bad = req_we ? !be_legal(req_wbyte_enable) : (req_wbyte_enable != BE_NONE);
`else
  assign be_bad = 1'b0;
`endif
  assign in_err = in_oor || be_bad;
  assign accept = state_q == IDLE && req_valid && !rst;
  assign ram_we = accept && req_we && !in_err;
  assign cur_idx = state_q == IDLE ? in_idx : idx_q;
  assign cur_we  = state_q == IDLE ? req_we : we_q;
  assign cur_err = state_q == IDLE ? in_err : err_q;
  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (req_wbyte_enable),
    .waddr (in_idx),
    .wdata (req_wdata),
    .raddr (cur_idx),
    .rdata (ram_rdata)
  );
  // next-state, latency countdown and response capture on entry to RESP
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    we_d = we_q;
    err_d = err_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d = resp_err_q;
    if (accept) begin
      idx_d = in_idx;
      we_d = req_we;
      err_d = in_err;
      cnt_d = 4'(LATENCY - 1);
      state_d = LATENCY == 1 ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
    end
    if (state_d == RESP && state_q != RESP) begin
      resp_err_d = cur_err;
      resp_rdata_d = (cur_err || cur_we) ? 32'd0 : ram_rdata;
    end
    req_ready_d = state_d == IDLE;
    resp_valid_d = state_d == RESP;
  end
  // state and registered handshake outputs; reset drops any pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      idx_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      we_q <= we_d;
      err_q <= err_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, corner sequences and randomized traffic against a word-array reference model
module tb_dmem_responder;
  localparam int LAT = 3;
  localparam int NW = 1024;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, resp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wbyte_enable = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, failures = 0;
  logic [31:0] mem_m [NW];
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t tbl [13];

  dmem_responder #(.DEPTH(NW), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wbyte_enable(req_wbyte_enable),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic w, input logic [3:0] be,
                                input logic [31:0] d, output logic [31:0] r, output logic e);
    int unsigned i;
    i = a[31:2];
    e = i >= NW;
`ifdef DMEM_BE_CHECK_EN
    if (w && !(be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111})) e = 1;
    if (!w && be != 0) e = 1;
`endif
    r = 0;
    if (!e && w)
      for (int n = 0; n < 4; n++) if (be[n]) mem_m[i][8*n +: 8] = d[8*n +: 8];
    if (!e && !w) r = mem_m[i];
  endfunction

  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready before send", {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_addr = a; req_we = w; req_wbyte_enable = be; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic do_req(input string nm, input logic [31:0] a, input logic w, input logic [3:0] be,
                        input logic [31:0] d, input int hold, input logic [31:0] er, input logic ee);
    int lat;
    bit ok;
    logic [31:0] r0;
    send(a, w, be, d);
    resp_ready = (hold == 0);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      check({nm, " req_ready low while waiting"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1; lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(LAT));
    check({nm, " rdata"}, resp_rdata, er);
    check({nm, " err"}, {31'd0, resp_err}, {31'd0, ee});
    r0 = resp_rdata;
    ok = 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== r0 || req_ready !== 1'b0) ok = 0;
    end
    if (hold > 0) check({nm, " stable under backpressure"}, {31'd0, ok}, 32'd1);
    resp_ready = 1;
    @(posedge clk); #1;
    check({nm, " idle after handshake"}, {30'd0, req_ready, resp_valid}, 32'b10);
  endtask

  initial begin
    logic [31:0] er, a, d, old;
    logic ee, w;
    logic [3:0] be;
    int hold;
    tbl[0]  = '{32'h10, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0};
    tbl[1]  = '{32'h10, 0, 4'h0, 32'h0, 32'hDEADBEEF, 0};
    tbl[2]  = '{32'h12, 1, 4'h4, 32'h00AA0000, 32'h0, 0};
    tbl[3]  = '{32'h10, 0, 4'h0, 32'h0, 32'hDEAABEEF, 0};
    tbl[4]  = '{32'h0, 1, 4'hF, 32'h12345678, 32'h0, 0};
    tbl[5]  = '{32'h1000, 1, 4'hF, 32'hCAFEF00D, 32'h0, 1};
    tbl[6]  = '{32'h0, 0, 4'h0, 32'h0, 32'h12345678, 0};
    tbl[7]  = '{32'h1000, 0, 4'h0, 32'h0, 32'h0, 1};
    tbl[8]  = '{32'h10, 1, 4'h0, 32'hFFFFFFFF, 32'h0, 0};
    tbl[9]  = '{32'h13, 0, 4'h0, 32'h0, 32'hDEAABEEF, 0};
`ifdef DMEM_BE_CHECK_EN
    tbl[10] = '{32'h10, 1, 4'h3, 32'h11112222, 32'h0, 1};
    tbl[11] = '{32'h10, 0, 4'h0, 32'h0, 32'hDEAABEEF, 0};
    tbl[12] = '{32'h10, 0, 4'h1, 32'h0, 32'h0, 1};
`else
    tbl[10] = '{32'h10, 1, 4'h3, 32'h11112222, 32'h0, 0};
    tbl[11] = '{32'h10, 0, 4'h0, 32'h0, 32'hDEAA2222, 0};
    tbl[12] = '{32'h10, 0, 4'h1, 32'h0, 32'hDEAA2222, 0};
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset flags ready/valid/err", {29'd0, req_ready, resp_valid, resp_err}, 32'b100);
    check("reset rdata", resp_rdata, 32'd0);
    rst = 0;
    foreach (tbl[i])
      do_req($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata, 0,
             tbl[i].exp_rdata, tbl[i].exp_err);
    do_req("backpressure load", 32'h0, 0, 4'h0, 32'h0, 5, 32'h12345678, 0);
    // reset while a load is in WAIT
    do_req("pre-store 0x40", 32'h40, 1, 4'hF, 32'hA5A5A5A5, 0, 32'h0, 0);
    send(32'h40, 0, 4'h0, 32'h0);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    check("rst in WAIT ready/valid", {30'd0, req_ready, resp_valid}, 32'b10);
    hold = 0;
    repeat (5) begin @(posedge clk); #1; if (resp_valid) hold++; end
    check("no response after rst", 32'(hold), 32'd0);
    // store accepted before a reset stays committed
    send(32'h44, 1, 4'hF, 32'h5A5A0000);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    do_req("store survives rst", 32'h44, 0, 4'h0, 32'h0, 0, 32'h5A5A0000, 0);
    // reset coinciding with a would-be acceptance blocks the write
    do_req("pre-store 0x48", 32'h48, 1, 4'hF, 32'h01020304, 0, 32'h0, 0);
    req_valid = 1; req_addr = 32'h48; req_we = 1; req_wbyte_enable = 4'hF; req_wdata = 32'hFFFFFFFF; rst = 1;
    @(posedge clk); #1;
    req_valid = 0; rst = 0;
    @(posedge clk); #1;
    check("rst+req no accept", {30'd0, req_ready, resp_valid}, 32'b10);
    do_req("rst+req no write", 32'h48, 0, 4'h0, 32'h0, 0, 32'h01020304, 0);
    // randomized traffic against the model over a small window plus out-of-range hits
    for (int k = 0; k < 16; k++) begin
      a = 32'h100 + 32'(4 * k);
      d = $urandom;
      model(a, 1, 4'hF, d, er, ee);
      do_req("rand init", a, 1, 4'hF, d, 0, er, ee);
    end
    for (int k = 0; k < 80; k++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3))
                                      : 32'h100 + 32'($urandom_range(0, 63));
      w = 1'($urandom);
      case ($urandom_range(0, 3))
        0: be = 4'hF;
        1: be = 4'b0001 << $urandom_range(0, 3);
        2: be = w ? 4'($urandom) : 4'h0;
        default: be = 4'($urandom);
      endcase
      d = $urandom;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      old = a;
      model(old, w, be, d, er, ee);
      do_req($sformatf("rand%0d", k), a, w, be, d, hold, er, ee);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
